fifo_rd_packer: RTL
===================

// Module: fifo_rd_packer
// PURPOSE
//  Read-domain consumer of asyn_fifo: pops DSIZE-bit entries (rdata/empty/read), packs RATIO of
//  them into one wide word and presents it on a valid/ready stream via a 2-entry output queue.
//  Sits between the async FIFO read port and the wide-datapath consumer; all logic on rclk.
// PARAMETERS
//  DSIZE    8   width of one FIFO entry (must match asyn_fifo DSIZE)
//  RATIO    4   entries packed per output word (>=2)
//  TIMEOUT  16  idle rclk cycles before a partial word is flushed (PACK_TIMEOUT_EN only, >=1)
// PORTS
//  rclk       in   1            clock (FIFO read clock)
//  rrst       in   1            asynchronous, active-high reset
//  empty      in   1            FIFO empty; rdata valid when 0
//  rdata      in   DSIZE        FIFO head entry (combinational from FIFO memory)
//  read       out  1            pop strobe to FIFO
//  out_data   out  DSIZE*RATIO  packed word; first popped entry in [DSIZE-1:0]
//  out_keep   out  RATIO        lane-valid mask, bit i covers lane i
//  out_valid  out  1            out_data/out_keep valid
//  out_ready  in   1            consumer accepts word when out_valid&&out_ready at rclk edge
// BEHAVIOUR
//  - Reset (async, rrst=1): lane=0, pack reg=0, queue count=0, FSM=S_IDLE, timeout cnt=0;
//    out_valid=0, out_data=0, out_keep=0, read=0 (read forced 0 while rrst=1).
//  - read = ~empty & ~stall & (state!=S_FLUSH); stall = (lane==RATIO-1) & (qcount==2).
//    read never depends combinationally on out_ready (no ready->read path).
//  - On pop: rdata latched into lane 'lane'; lane increments; at lane==RATIO-1 the completed word
//    (pack reg + current rdata) pushes into the queue in the same edge, lane wraps to 0, pack reg clears.
//  - Latency: out_valid rises the cycle after the pop of the RATIO-th entry. Sustained 1 entry/cycle
//    with out_ready=1 (word every RATIO cycles, no bubbles).
//  - Output queue: 2 entries, FIFO order, out_* driven from registered head, out_valid=(qcount!=0).
//    Push only when qcount<2; push+pop same edge keeps count; pop at count 0 impossible.
//    out_data/out_keep held stable while out_valid&&!out_ready.
//  - FSM: S_IDLE (lane==0) -pop-> S_FILL; S_FILL -word complete-> S_IDLE;
//    S_FILL -timeout (macro only)-> S_FLUSH; S_FLUSH -push done (qcount<2)-> S_IDLE.
//  - Lane counter width clog2(RATIO); wraps RATIO-1 -> 0, never exceeds RATIO-1.
//  - Reset mid-operation: partial word and queued words discarded; already-popped entries lost.
// CONFIGURATION
//  PACK_TIMEOUT_EN defined:
//   - in S_FILL a counter increments each cycle with no pop, clears on pop; at count==TIMEOUT-1
//     without pop -> S_FLUSH. S_FLUSH pushes the partial word when qcount<2: filled lanes keep
//     popped data, unused lanes 0, out_keep bit i =1 for i<lane; then lane=0, S_IDLE. No pop in S_FLUSH.
//  PACK_TIMEOUT_EN undefined:
//   - no counter, no S_FLUSH; partial word held indefinitely until completed;
//     out_keep = {RATIO{1'b1}} whenever out_valid, 0 otherwise (TIMEOUT unused).
// TESTING (DSIZE=8, RATIO=4)
//  1. Assert rrst mid-clock -> read=0,out_valid=0,out_data=0,out_keep=0 immediately, no rclk edge needed.
//  2. empty=0, rdata 0x11..0x18 one per pop, out_ready=1 -> read high 8 cycles; words 0x14131211 then
//     0x18171615, out_keep=4'hF, out_valid first high cycle after 4th pop.
//  3. out_ready=0, 12 entries available -> 11 pops, read stuck 0 with lane==3,qcount==2;
//     out_ready=1 -> 0x..04030201, 0x..08070605, 0x..0C0B0A09 in order, 12th pop occurs.
//  4. empty toggles each cycle -> read never high while empty=1; words assemble identical to test 2.
//  5. Macro on, TIMEOUT=16: pop 0xA1,0xA2,0xA3 then empty=1 -> after 16 idle cycles out_valid with
//     out_data=0x00A3A2A1, out_keep=4'b0111; macro off -> no out_valid within 100 cycles.
//  6. Pop 2 entries, pulse rrst, then pop 0x31..0x34 -> single word 0x34333231, keep 4'hF, no stale lanes.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// Read-port and packed-stream signals of fifo_rd_packer.
// master = the packer; slave = the FIFO read port plus the wide-word consumer.
interface fifo_rd_packer_if #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned RATIO = 4
);
  logic                   empty;
  logic [DSIZE-1:0]       rdata;
  logic                   read;
  logic [DSIZE*RATIO-1:0] out_data;
  logic [RATIO-1:0]       out_keep;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  empty, rdata, out_ready,
    output read, out_data, out_keep, out_valid
  );

  modport slave (
    output empty, rdata, out_ready,
    input  read, out_data, out_keep, out_valid
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops DSIZE-bit FIFO entries, packs RATIO of them per word, and streams words through a 2-deep queue.
// Optional partial-word flush after TIMEOUT idle cycles when PACK_TIMEOUT_EN is defined.
module fifo_rd_packer #(
  parameter int unsigned DSIZE   = 8,
  parameter int unsigned RATIO   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  fifo_rd_packer_if.master bus
);
  localparam int unsigned LW = $clog2(RATIO);
  localparam int unsigned WW = DSIZE * RATIO;
  localparam logic [LW-1:0] LAST = LW'(RATIO - 1);

`ifdef PACK_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FILL} state_t;
`endif

  state_t          state_q, state_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [WW-1:0]   pack_q, pack_d;
  logic [WW-1:0]   q0_data_q, q0_data_d, q1_data_q, q1_data_d;
  logic [1:0]      qcount_q, qcount_d;
`ifdef PACK_TIMEOUT_EN
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RATIO-1:0] q0_keep_q, q0_keep_d, q1_keep_q, q1_keep_d;
  logic [RATIO-1:0] part_keep_c;
`endif

  logic            stall_c, read_c, pop_c, push_c;
  logic [WW-1:0]   word_c, push_data_c;
  logic [RATIO-1:0] push_keep_c;

  // Packing, FSM and 2-entry output queue next-state
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    q0_data_d   = q0_data_q;
    q1_data_d   = q1_data_q;
    qcount_d    = qcount_q;
    push_c      = 1'b0;
    push_data_c = pack_q;
    push_keep_c = '1;
`ifdef PACK_TIMEOUT_EN
    cnt_d       = cnt_q;
    q0_keep_d   = q0_keep_q;
    q1_keep_d   = q1_keep_q;
    for (int i = 0; i < int'(RATIO); i++) part_keep_c[i] = (i < int'(lane_q));
`endif

    // Stall only on the completing pop, so read never waits on out_ready
    stall_c = (lane_q == LAST) && (qcount_q == 2'd2);
    read_c  = !rrst && !bus.empty && !stall_c;
`ifdef PACK_TIMEOUT_EN
    read_c  = read_c && (state_q != S_FLUSH);
`endif
    pop_c   = (qcount_q != 2'd0) && bus.out_ready;

    word_c = pack_q;
    word_c[int'(lane_q)*DSIZE +: DSIZE] = bus.rdata;

    if (read_c) begin
      if (lane_q == LAST) begin
        push_c      = 1'b1;
        push_data_c = word_c;
        lane_d      = '0;
        pack_d      = '0;
        state_d     = S_IDLE;
      end else begin
        pack_d  = word_c;
        lane_d  = lane_q + LW'(1);
        state_d = S_FILL;
      end
`ifdef PACK_TIMEOUT_EN
      cnt_d = '0;
    end else if (state_q == S_FILL) begin
      if (cnt_q == CW'(TIMEOUT - 1)) begin
        cnt_d   = '0;
        state_d = S_FLUSH;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if ((state_q == S_FLUSH) && (qcount_q != 2'd2)) begin
      push_c      = 1'b1;
      push_data_c = pack_q;
      push_keep_c = part_keep_c;
      lane_d      = '0;
      pack_d      = '0;
      state_d     = S_IDLE;
`endif
    end

    case ({push_c, pop_c})
      2'b10: begin
        if (qcount_q == 2'd0) begin
          q0_data_d = push_data_c;
`ifdef PACK_TIMEOUT_EN
          q0_keep_d = push_keep_c;
`endif
        end else begin
          q1_data_d = push_data_c;
`ifdef PACK_TIMEOUT_EN
          q1_keep_d = push_keep_c;
`endif
        end
        qcount_d = qcount_q + 2'd1;
      end
      2'b01: begin
        q0_data_d = q1_data_q;
`ifdef PACK_TIMEOUT_EN
        q0_keep_d = q1_keep_q;
`endif
        qcount_d  = qcount_q - 2'd1;
      end
      2'b11: begin
        if (qcount_q == 2'd1) begin
          q0_data_d = push_data_c;
`ifdef PACK_TIMEOUT_EN
          q0_keep_d = push_keep_c;
`endif
        end else begin
          q0_data_d = q1_data_q;
          q1_data_d = push_data_c;
`ifdef PACK_TIMEOUT_EN
          q0_keep_d = q1_keep_q;
          q1_keep_d = push_keep_c;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      pack_q    <= '0;
      q0_data_q <= '0;
      q1_data_q <= '0;
      qcount_q  <= 2'd0;
`ifdef PACK_TIMEOUT_EN
      cnt_q     <= '0;
      q0_keep_q <= '0;
      q1_keep_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      q0_data_q <= q0_data_d;
      q1_data_q <= q1_data_d;
      qcount_q  <= qcount_d;
`ifdef PACK_TIMEOUT_EN
      cnt_q     <= cnt_d;
      q0_keep_q <= q0_keep_d;
      q1_keep_q <= q1_keep_d;
`endif
    end
  end

  assign bus.read      = read_c;
  assign bus.out_valid = (qcount_q != 2'd0);
  assign bus.out_data  = q0_data_q;
`ifdef PACK_TIMEOUT_EN
  assign bus.out_keep  = (qcount_q != 2'd0) ? q0_keep_q : '0;
`else
  assign bus.out_keep  = {RATIO{qcount_q != 2'd0}};
`endif
endmodule
